keypad_entry: RTL and testbench

- Scans a 4x4 matrix keypad, debounces key presses and turns digit keys into single-cycle (dig, pos, wr) write commands for the 8-digit display controller.
- Keeps the entry pointer, so digits fill positions 0..7 in order.
- Reports operator and function keys separately on op_code/op_valid for the calculator datapath.
- Sits between the board keypad pins and the display/calculator control.

---
 rtl/keypad_entry_if.sv | 13 +
 rtl/keypad_entry.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Display-write and calculator command bundle driven by keypad_entry.
interface keypad_entry_if;
  logic [3:0] dig;
  logic [3:0] pos;
  logic       wr;
  logic [3:0] op_code;
  logic       op_valid;
  logic       clr;
  logic       full;

  modport master (output dig, pos, wr, op_code, op_valid, clr, full);
  modport slave  (input  dig, pos, wr, op_code, op_valid, clr, full);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner/debouncer producing display writes and operator commands.
// Optional auto-repeat of digit/backspace keys is enabled by defining KEYPAD_REPEAT_EN.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        col_n,
  output logic [3:0]        row_n,
  keypad_entry_if.master    disp
);
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  // Empty named blocks flag out-of-range parameters in the elaborated hierarchy.
  if (SCAN_DIV < 4)     begin : g_scan_div_too_small end
  if (DEBOUNCE_CYC < 2) begin : g_debounce_cyc_too_small end
  if (REPEAT_CYC < 1)   begin : g_repeat_cyc_too_small end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       col_s1_reg, col_s2_reg;
  logic [1:0]       row_reg, row_next;
  logic [1:0]       col_reg, col_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DEB_W-1:0] deb_reg, deb_next;
  logic [3:0]       ptr_reg, ptr_next;
  logic [3:0]       dig_reg, dig_next;
  logic [3:0]       pos_reg, pos_next;
  logic [3:0]       op_code_reg, op_code_next;
  logic             wr_reg, wr_next;
  logic             op_valid_reg, op_valid_next;
  logic             clr_reg, clr_next;
  logic             full_reg;

  logic [3:0]       col_hit;
  logic             key_low;
  logic             any_low;
  logic [1:0]       low_col;
  logic [3:0]       code;
  logic             do_action;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 2) ? $clog2(REPEAT_CYC) : 1;
  logic [REP_W-1:0] rep_reg, rep_next;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd1;  4'h1: key_code = 4'd2;  4'h2: key_code = 4'd3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'd4;  4'h5: key_code = 4'd5;  4'h6: key_code = 4'd6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'd7;  4'h9: key_code = 4'd8;  4'hA: key_code = 4'd9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  4'hD: key_code = 4'd0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  assign row_n = ~(4'b0001 << row_reg);
  assign code  = key_code(row_reg, col_reg);

  // Only the latched column matters once a key has been chosen.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col_hit
    assign col_hit[gi] = (col_reg == 2'(gi)) & ~col_s2_reg[gi];
  end
  assign key_low = |col_hit;
  assign any_low = ~&col_s2_reg;

  always_comb begin
    low_col = 2'd0;
    casez (col_s2_reg)
      4'b???0: low_col = 2'd0;
      4'b??01: low_col = 2'd1;
      4'b?011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: low_col = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= SCAN;
      col_s1_reg   <= 4'hF;
      col_s2_reg   <= 4'hF;
      row_reg      <= 2'd0;
      col_reg      <= 2'd0;
      div_reg      <= '0;
      deb_reg      <= '0;
      ptr_reg      <= 4'd0;
      dig_reg      <= 4'd0;
      pos_reg      <= 4'd0;
      op_code_reg  <= 4'd0;
      wr_reg       <= 1'b0;
      op_valid_reg <= 1'b0;
      clr_reg      <= 1'b0;
      full_reg     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      col_s1_reg   <= col_n;
      col_s2_reg   <= col_s1_reg;
      row_reg      <= row_next;
      col_reg      <= col_next;
      div_reg      <= div_next;
      deb_reg      <= deb_next;
      ptr_reg      <= ptr_next;
      dig_reg      <= dig_next;
      pos_reg      <= pos_next;
      op_code_reg  <= op_code_next;
      wr_reg       <= wr_next;
      op_valid_reg <= op_valid_next;
      clr_reg      <= clr_next;
      full_reg     <= (ptr_next == 4'd8);
`ifdef KEYPAD_REPEAT_EN
      rep_reg      <= rep_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    div_next      = div_reg;
    deb_next      = deb_reg;
    ptr_next      = ptr_reg;
    dig_next      = dig_reg;
    pos_next      = pos_reg;
    op_code_next  = op_code_reg;
    wr_next       = 1'b0;
    op_valid_next = 1'b0;
    clr_next      = 1'b0;
    do_action     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next      = rep_reg;
`endif

    case (state_reg)
      SCAN: begin
        if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
          div_next = '0;
          if (any_low) begin
            col_next   = low_col;
            deb_next   = '0;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (key_low) begin
          if (deb_reg == DEB_W'(DEBOUNCE_CYC - 1)) begin
            deb_next   = '0;
            state_next = EMIT;
          end else begin
            deb_next = deb_reg + 1'b1;
          end
        end else begin
          deb_next   = '0;
          row_next   = row_reg + 2'd1;
          state_next = SCAN;
        end
      end
      EMIT: begin
        do_action  = 1'b1;
        deb_next   = '0;
        state_next = WAIT_REL;
`ifdef KEYPAD_REPEAT_EN
        rep_next   = '0;
`endif
      end
      default: begin
        if (key_low) begin
          deb_next = '0;
`ifdef KEYPAD_REPEAT_EN
          if (rep_reg == REP_W'(REPEAT_CYC - 1)) begin
            rep_next  = '0;
            do_action = (code <= 4'd9) || (code == 4'hB);
          end else begin
            rep_next = rep_reg + 1'b1;
          end
`endif
        end else begin
`ifdef KEYPAD_REPEAT_EN
          rep_next = '0;
`endif
          if (deb_reg == DEB_W'(DEBOUNCE_CYC - 1)) begin
            deb_next   = '0;
            row_next   = row_reg + 2'd1;
            state_next = SCAN;
          end else begin
            deb_next = deb_reg + 1'b1;
          end
        end
      end
    endcase

    // Key action: at most one of wr/op_valid/clr is raised per action.
    if (do_action) begin
      if (code <= 4'd9) begin
        if (ptr_reg != 4'd8) begin
          wr_next  = 1'b1;
          dig_next = code;
          pos_next = ptr_reg;
          ptr_next = ptr_reg + 4'd1;
        end
      end else if (code == 4'hB) begin
        if (ptr_reg != 4'd0) begin
          wr_next  = 1'b1;
          dig_next = 4'd0;
          pos_next = ptr_reg - 4'd1;
          ptr_next = ptr_reg - 4'd1;
        end
      end else if (code == 4'hC) begin
        clr_next = 1'b1;
        ptr_next = 4'd0;
      end else begin
        op_valid_next = 1'b1;
        op_code_next  = code;
        ptr_next      = 4'd0;
      end
    end
  end

  assign disp.dig      = dig_reg;
  assign disp.pos      = pos_reg;
  assign disp.wr       = wr_reg;
  assign disp.op_code  = op_code_reg;
  assign disp.op_valid = op_valid_reg;
  assign disp.clr      = clr_reg;
  assign disp.full     = full_reg;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural single-key matrix model.
module tb_keypad_entry;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       pressed = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ev_n    = 0;
  int ev_kind [16];
  int ev_val  [16];
  int ev_pos  [16];
  int viol    = 0;
  logic wr_q = 1'b0, opv_q = 1'b0, clr_q = 1'b0;
  logic [3:0] row_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam logic [3:0] KEY_A = 4'b0011;
  localparam logic [3:0] KEY_B = 4'b0111;
  localparam logic [3:0] KEY_C = 4'b1011;
  localparam logic [3:0] KEY_F = 4'b1110;

  keypad_entry_if disp_if ();

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CYC(8), .REPEAT_CYC(40)) dut (
    .clock (clock),
    .reset (reset),
    .col_n (col_n),
    .row_n (row_n),
    .disp  (disp_if)
  );

  always #5 clock = ~clock;

  always_comb begin
    col_n = 4'hF;
    if (pressed && row_n[key_row] == 1'b0) col_n = ~(4'b0001 << key_col);
  end

  // Event logger plus strobe width / exclusivity watch.
  always @(negedge clock) begin
    if (disp_if.wr && ev_n < 16) begin
      ev_kind[ev_n] = 1; ev_val[ev_n] = int'(disp_if.dig); ev_pos[ev_n] = int'(disp_if.pos); ev_n++;
    end
    if (disp_if.op_valid && ev_n < 16) begin
      ev_kind[ev_n] = 2; ev_val[ev_n] = int'(disp_if.op_code); ev_pos[ev_n] = 0; ev_n++;
    end
    if (disp_if.clr && ev_n < 16) begin
      ev_kind[ev_n] = 3; ev_val[ev_n] = 0; ev_pos[ev_n] = 0; ev_n++;
    end
    if (int'(disp_if.wr) + int'(disp_if.op_valid) + int'(disp_if.clr) > 1) viol++;
    if ((disp_if.wr && wr_q) || (disp_if.op_valid && opv_q) || (disp_if.clr && clr_q)) viol++;
    if (disp_if.pos > 4'd7) viol++;
    wr_q  = disp_if.wr;
    opv_q = disp_if.op_valid;
    clr_q = disp_if.clr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] digit_key(input int d);
    case (d)
      0: digit_key = 4'b1101;  1: digit_key = 4'b0000;  2: digit_key = 4'b0001;
      3: digit_key = 4'b0010;  4: digit_key = 4'b0100;  5: digit_key = 4'b0101;
      6: digit_key = 4'b0110;  7: digit_key = 4'b1000;  8: digit_key = 4'b1001;
      default: digit_key = 4'b1010;
    endcase
  endfunction

  task automatic press(input logic [3:0] rc, input int hold, input string name);
    key_row = rc[3:2];
    key_col = rc[1:0];
    ev_n    = 0;
    pressed = 1'b1;
    repeat (hold) @(negedge clock);
    pressed = 1'b0;
    repeat (24) @(negedge clock);
    $display("key %s (r%0d c%0d): %0d events", name, key_row, key_col, ev_n);
  endtask

  task automatic wait_row(input logic [3:0] target);
    for (int i = 0; i < 64 && row_n !== target; i++) @(negedge clock);
    chk("wait_row", row_n, target);
  endtask

  task automatic expect_wr(input string tag, input int d, input int p);
    chk({tag, ".n"}, ev_n, 1);
    chk({tag, ".kind"}, ev_kind[0], 1);
    chk({tag, ".dig"}, ev_val[0], d);
    chk({tag, ".pos"}, ev_pos[0], p);
  endtask

  task automatic expect_ev(input string tag, input int kind, input int val);
    chk({tag, ".n"}, ev_n, 1);
    chk({tag, ".kind"}, ev_kind[0], kind);
    chk({tag, ".val"}, ev_val[0], val);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".row_n"}, row_n, 4'b1110);
    chk({tag, ".dig"}, disp_if.dig, 0);
    chk({tag, ".pos"}, disp_if.pos, 0);
    chk({tag, ".wr"}, disp_if.wr, 0);
    chk({tag, ".op_code"}, disp_if.op_code, 0);
    chk({tag, ".op_valid"}, disp_if.op_valid, 0);
    chk({tag, ".clr"}, disp_if.clr, 0);
    chk({tag, ".full"}, disp_if.full, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    ev_n = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      chk($sformatf("scan%0d", i), row_n, row_tab[i / 4]);
    end
    chk("scan.no_strobe", ev_n, 0);

    press(digit_key(5), 30, "5");
    expect_wr("five0", 5, 0);
    press(digit_key(5), 30, "5");
    expect_wr("five1", 5, 1);

    press(KEY_C, 30, "C");
    expect_ev("clr0", 3, 0);
    for (int i = 0; i < 10; i++) begin
      press(digit_key((i + 1) % 10), 30, $sformatf("%0d", (i + 1) % 10));
      if (i < 8) expect_wr($sformatf("fill%0d", i), (i + 1) % 10, i);
      else       chk($sformatf("drop%0d", i), ev_n, 0);
      if (i == 6) chk("full7", disp_if.full, 0);
      if (i == 7) chk("full8", disp_if.full, 1);
    end
    press(KEY_B, 30, "B");
    expect_wr("bksp", 0, 7);
    chk("full_after_bksp", disp_if.full, 0);

    press(KEY_C, 30, "C");
    expect_ev("clr1", 3, 0);
    press(digit_key(3), 30, "3");
    expect_wr("three", 3, 0);
    press(KEY_A, 30, "A");
    expect_ev("opA", 2, 10);
    press(digit_key(4), 30, "4");
    expect_wr("after_op", 4, 0);
    press(KEY_C, 30, "C");
    expect_ev("clr2", 3, 0);
    press(KEY_B, 30, "B");
    chk("bksp_empty", ev_n, 0);
    press(KEY_F, 30, "F");
    expect_ev("opF", 2, 15);

    // Bouncy "7": short low, short high, then stable low.
    key_row = 2'd2; key_col = 2'd0; ev_n = 0;
    pressed = 1'b1; repeat (3) @(negedge clock);
    pressed = 1'b0; repeat (2) @(negedge clock);
    pressed = 1'b1; repeat (40) @(negedge clock);
    pressed = 1'b0; repeat (24) @(negedge clock);
    $display("key 7 bounced: %0d events", ev_n);
    expect_wr("bounce7", 7, 0);
    press(digit_key(5), 5, "5 glitch");
    chk("glitch", ev_n, 0);

    press(digit_key(8), 30, "8");
    expect_wr("eight", 8, 1);

    // Reset while "9" is being debounced.
    wait_row(4'b1101);
    key_row = 2'd2; key_col = 2'd2; ev_n = 0; pressed = 1'b1;
    wait_row(4'b1011);
    repeat (6) @(negedge clock);
    reset = 1'b0; pressed = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    repeat (40) @(negedge clock);
    $display("key 9 aborted by reset: %0d events", ev_n);
    chk("mid_reset.no_wr", ev_n, 0);
    press(digit_key(1), 30, "1");
    expect_wr("ptr_cleared", 1, 0);
    press(KEY_C, 30, "C");
    expect_ev("clr3", 3, 0);

    // Long hold of "2", aligned to the start of row 0.
    wait_row(4'b0111);
    wait_row(4'b1110);
    press(digit_key(2), 100, "2 held");
`ifdef KEYPAD_REPEAT_EN
    chk("rep.n", ev_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rep%0d.dig", i), ev_val[i], 2);
      chk($sformatf("rep%0d.pos", i), ev_pos[i], i);
    end
`else
    expect_wr("hold_once", 2, 0);
`endif

    chk("strobe_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
